lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller sitting directly downstream of the ALU. It takes the ALU result as the effective address and sequences a single data-memory access over a request/grant/response bus. It generates byte enables and write-data lane replication, then returns aligned, sign- or zero-extended load data to writeback. The core pipeline stalls on `req_rdy` low until `rsp_vld` pulses.

## Interface
- `TIMEOUT`, 16: maximum bus wait cycles (across REQ and WAIT combined) before abort with error; legal range 2..255.
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_vld`  in  1  core presents an access
- `req_rdy`  out  1  high only in IDLE; a request is accepted on `req_vld && req_rdy`
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- `req_uns`  in  1  zero-extend loads (LBU/LHU)
- `req_addr`  in  `CPU_WIDTH`  effective address (ALU result)
- `req_wdata`  in  `CPU_WIDTH`  store data (rs2)
- `rsp_vld`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  `CPU_WIDTH`  extended load data; 0 for stores and on error
- `rsp_err`  out  1  qualifies `rsp_vld`: timeout or misalign
- `mem_req`  out  1  bus request, held until `mem_gnt`
- `mem_we`  out  1  bus write
- `mem_addr`  out  `CPU_WIDTH`  word-aligned address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  `CPU_WIDTH`  lane-replicated store data
- `mem_gnt`  in  1  bus accepts the request
- `mem_rvld`  in  1  read data valid
- `mem_rdata`  in  `CPU_WIDTH`  read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- Accept (IDLE): register `we`, `size`, `uns`, `addr`, `wdata`; clear the timeout counter; go to REQ.
- REQ: `mem_req`=1 with stable `mem_*` fields.
  - On `mem_gnt`, a store goes to RESP and a load goes to WAIT.
- WAIT: on `mem_rvld`, capture the extracted data and go to RESP. `mem_rvld` is ignored in every other state.
- RESP: `rsp_vld`=1 for exactly one cycle, then IDLE.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<{addr[1],1'b0}`
  - word: `4'b1111`
  - `mem_be` is driven for loads too.
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extract: `mem_rdata >> (8*addr[1:0])` (half uses `addr[1]` only). Take the low 8 or 16 bits, then sign-extend, or zero-extend when `uns`=1. Word loads pass through unchanged.
- Timeout: the counter increments every cycle in REQ or WAIT. If it reaches `TIMEOUT-1` with no completing event (`mem_gnt` in REQ, `mem_rvld` in WAIT), go to RESP with `rsp_err`=1, `rsp_rdata`=0 and `mem_req` dropped. If the completing event arrives in that same final cycle, the event wins and there is no error.
- `mem_req`, `mem_we`, `mem_be`, `mem_wdata` and `mem_addr` are 0 outside REQ.

## Timing
- Reset (asynchronous): state IDLE, `req_rdy`=1. All other outputs are 0; captured registers and counter are 0.
- Reset mid-access returns to IDLE immediately and deasserts `mem_req`; no `rsp_vld` is produced.
- Accept at cycle 0, `mem_req` at cycle 1.
- Store, `mem_gnt` at cycle 1: `rsp_vld` at cycle 2.
- Load, gnt at cycle 1 and `mem_rvld` at cycle 2: `rsp_vld` at cycle 3. Each extra wait cycle adds one.
- `req_rdy` is 0 from cycle 1 until the cycle after `rsp_vld`. Back-to-back accesses are possible on the cycle after RESP.
- `rsp_rdata` and `rsp_err` are valid only while `rsp_vld`=1 and are 0 otherwise.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined:
  - A half with `addr[0]`=1, or a word with `addr[1:0]`≠0, is accepted, skips REQ/WAIT, and goes directly to RESP.
  - `rsp_vld`=1 and `rsp_err`=1 at cycle 1; `mem_req` is never raised.
- `LSU_MISALIGN_CHK_EN` undefined:
  - There is no check. Offending low address bits are ignored per the byte-enable and extract rules, and the access proceeds normally.

## Test plan
- Reset with `req_vld`=1 held: `req_rdy`=1, `mem_req`=0, `rsp_vld`=0 throughout reset.
- SB addr 0x1003, wdata 0x000000A5, immediate gnt → `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `rsp_vld` at cycle 2 with `rsp_err`=0.
- LH addr 0x2002, `mem_rdata`=0x80FF1234, rvld 3 cycles after gnt → `rsp_rdata`=0xFFFF80FF. Same access with LHU → 0x000080FF.
- LW, `mem_gnt` withheld, `TIMEOUT`=16 → `mem_req` high for 16 cycles, then `rsp_vld`=1, `rsp_err`=1, `rsp_rdata`=0. Repeat with gnt in cycle 16 → no error.
- LW addr 0x3001:
  - With `LSU_MISALIGN_CHK_EN`: `rsp_err`=1 at cycle 1 and no `mem_req`.
  - Without: `mem_addr`=0x3000, `mem_be`=1111, normal response.
- Assert `rst_n` low while in WAIT → `mem_req`=0 and `req_rdy`=1 immediately. A new SW after release completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store controller: one data-memory access per request over a req/gnt/rvld bus.
// Define LSU_MISALIGN_CHK_EN to fault misaligned half/word accesses without touching the bus.
module lsu_ctrl #(
  parameter int CPU_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_uns,
  input  logic [CPU_WIDTH-1:0] req_addr,
  input  logic [CPU_WIDTH-1:0] req_wdata,
  output logic                 rsp_vld,
  output logic [CPU_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [CPU_WIDTH-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [CPU_WIDTH-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvld,
  input  logic [CPU_WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                 we;
    logic [1:0]           size;
    logic                 uns;
    logic [CPU_WIDTH-1:0] addr;
    logic [CPU_WIDTH-1:0] wdata;
  } acc_t;

  state_t               state_q, state_d;
  acc_t                 acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 misalign;
  logic                 to_hit;
  logic [7:0]           ld_b;
  logic [15:0]          ld_h;
  logic [CPU_WIDTH-1:0] ld_ext;
  logic [3:0]           be;
  logic [CPU_WIDTH-1:0] wdata_rep;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // The counter can step one past TO_LAST when the grant lands in the final
  // REQ cycle, so compare with >= to keep the WAIT phase bounded too.
  assign to_hit = (cnt_q >= TO_LAST);

  // Lane selection of the returned word, then sign/zero extension.
  always_comb begin
    ld_b = 8'h00;
    case (acc_q.addr[1:0])
      2'd0:    ld_b = mem_rdata[7:0];
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    ld_h = acc_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (acc_q.size)
      2'b00:   ld_ext = {{(CPU_WIDTH-8){~acc_q.uns & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{(CPU_WIDTH-16){~acc_q.uns & ld_h[15]}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (acc_q.size)
      2'b00: begin
        be        = 4'b0001 << acc_q.addr[1:0];
        wdata_rep = {4{acc_q.wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {acc_q.addr[1], 1'b0};
        wdata_rep = {2{acc_q.wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = acc_q.wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          acc_d   = '{we: req_we, size: req_size, uns: req_uns,
                      addr: req_addr, wdata: req_wdata};
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = misalign;
          state_d = misalign ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          state_d = acc_q.we ? S_RESP : S_WAIT;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvld) begin
          rdata_d = ld_ext;
          state_d = S_RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_rdy   = (state_q == S_IDLE);
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req & acc_q.we;
    mem_addr  = mem_req ? {acc_q.addr[CPU_WIDTH-1:2], 2'b00} : '0;
    mem_be    = mem_req ? be : 4'b0000;
    mem_wdata = mem_req ? wdata_rep : '0;
    rsp_vld   = (state_q == S_RESP);
    rsp_rdata = rsp_vld ? rdata_q : '0;
    rsp_err   = rsp_vld & err_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed cases plus randomized accesses against a bus responder.
module tb_lsu_ctrl;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld, req_rdy, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_vld, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvld;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_ctrl #(.CPU_WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_size(req_size),
    .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  // Expected bus request fields for the access in flight.
  logic        eb_we;
  logic [3:0]  eb_be;
  logic [31:0] eb_addr, eb_wdata;

  // Bus responder: grant on REQ cycle rs_g, read data on WAIT cycle rs_r.
  int          rs_g = 1, rs_r = 1;
  bit          rs_load = 1'b0;
  logic [31:0] rs_rdata = '0;
  int          ph = 0, rcnt = 0, wcnt = 0;
  logic        prev_req = 1'b0;

  always @(negedge clk) begin
    mem_gnt   = 1'b0;
    mem_rvld  = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!prev_req) begin ph = 1; rcnt = 0; end
      rcnt++;
      if (rcnt == rs_g) begin
        mem_gnt = 1'b1;
        ph      = rs_load ? 2 : 0;
        wcnt    = 0;
      end
    end else if (ph == 2) begin
      wcnt++;
      if (wcnt == rs_r) begin
        mem_rvld  = 1'b1;
        mem_rdata = rs_rdata;
        ph        = 0;
      end
    end
    // Stray read-valid pulses outside WAIT must be ignored by the controller.
    if (ph != 2 && !mem_rvld) mem_rvld = ($urandom_range(3) == 0);
    prev_req = mem_req;
  end

  // Monitor: bus fields every cycle, responses popped from the scoreboard.
  always @(negedge clk) begin
    if (mem_req) begin
      chk("mem_addr", mem_addr, eb_addr);
      chk("mem_be_we", {27'b0, eb_we, eb_be} ^ {27'b0, mem_we, mem_be}, 32'h0);
      chk("mem_wdata", mem_wdata, eb_wdata);
    end else begin
      chk("bus_idle_zero", mem_addr | mem_wdata | {28'b0, mem_be} | {31'b0, mem_we}, 32'h0);
    end
    if (rsp_vld) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_vld), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", 32'(cyc), 32'(e.at));
      end
    end else begin
      chk("rsp_idle_zero", rsp_rdata | {31'b0, rsp_err}, 32'h0);
    end
  end

  function automatic logic [31:0] extract(logic [31:0] rd, logic [1:0] sz, logic uns, logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic set_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int g, input int r, input logic [31:0] rd);
    exp_t e;
    bit   mis;
    int   nto;
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
    e.rdata = 32'h0;
    e.err   = 1'b0;
    if (mis) begin
      e.err = 1'b1; e.at = cyc + 1;
    end else if (g > T) begin
      e.err = 1'b1; e.at = cyc + T + 1;
    end else if (we) begin
      e.at = cyc + g + 1;
    end else begin
      nto = (T > g + 1) ? T : g + 1;
      if (g + r > nto) begin
        e.err = 1'b1; e.at = cyc + nto + 1;
      end else begin
        e.at = cyc + g + r + 1;
        e.rdata = extract(rd, sz, uns, a);
      end
    end
    eb_we    = we;
    eb_addr  = {a[31:2], 2'b00};
    eb_be    = (sz == 2'b00) ? 4'(1 << a[1:0]) : (sz == 2'b01) ? (a[1] ? 4'hC : 4'h3) : 4'hF;
    eb_wdata = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
    rs_g = g; rs_r = r; rs_load = !we; rs_rdata = rd;
    req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    req_vld = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!req_rdy && n < 100) begin @(negedge clk); n++; end
    if (!req_rdy) chk("req_rdy_timeout", 32'(req_rdy), 32'h1);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int r, input logic [31:0] rd);
    int n = 0;
    wait_rdy();
    set_access(we, sz, uns, a, wd, g, r, rd);
    @(negedge clk);
    req_vld = 1'b0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_vld = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_rdy", 32'(req_rdy), 32'h1);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    end
    req_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1, 1, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1, 3, 32'h80FF_1234);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 1, 3, 32'h80FF_1234);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 100, 1, 32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, T, 1, 32'h1234_5678);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_4004, 32'hCAFE_F00D, T, 1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 1, 1, 32'hDEAD_BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_5003, 32'h0, 2, 2, 32'h80_00_00_00);

    // Reset in the middle of a load's WAIT phase.
    wait_rdy();
    rs_g = 1; rs_r = 50; rs_load = 1'b1;
    eb_we = 1'b0; eb_addr = 32'h0000_6000; eb_be = 4'hF; eb_wdata = 32'h0;
    req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h0000_6000; req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    chk("wait_req_rdy", 32'(req_rdy), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'h0);
    chk("midrst_req_rdy", 32'(req_rdy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_7008, 32'h0BAD_CAFE, 1, 1, 32'h0);

    for (int i = 0; i < 250; i++) begin
      logic [1:0] sz;
      int g, r;
      sz = 2'($urandom_range(3));
      g = ($urandom_range(9) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 4);
      r = ($urandom_range(9) == 0) ? $urandom_range(5, 18) : $urandom_range(1, 3);
      repeat ($urandom_range(2)) @(negedge clk);
      issue(1'($urandom_range(1)), sz, 1'($urandom_range(1)), $urandom, $urandom, g, r, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
